rps_match_engine: RTL
=====================

// Module: rps_match_engine
// PURPOSE
//  Parametrised rock-paper-scissors match controller; successor to the free-running punch/LFSR game block.
//  Synchronises player punch buttons, draws an unbiased CPU choice from a width-parametrised LFSR,
//  judges each round, keeps scores, ends the match at WIN_SCORE. Feeds the LED-matrix and 7-seg drivers.
// PARAMETERS
//  LFSR_W        16        LFSR width (>=4)
//  TAPS          16'hB400  feedback mask; fb = ^(lfsr & TAPS), shift left, fb into bit 0
//  SEED          16'h0001  reset value of lfsr; SEED==0 is replaced by 1
//  REVEAL_CYCLES 8         cycles result is shown before the next round may start (>=1)
//  WIN_SCORE     3         score that ends the match (1..2**SCORE_W-1)
//  SCORE_W       4         width of each score counter
//  ROUND_W       6         width of the round counter (wraps)
// PORTS
//  CLK          in   1        system clock, all flops posedge
//  Clear        in   1        asynchronous, active-low reset
//  punch        in   3        raw buttons, one-hot: 001 scissors, 010 stone, 100 paper
//  new_match    in   1        sync pulse: clear scores/rounds, restart match
//  force_en     in   1        test override: CPU choice taken from force_choice
//  force_choice in   2        00 scissors, 01 stone, 10 paper (11 treated as retry)
//  player_choice out 2        latched player choice (same encoding)
//  cpu_choice   out  2        latched CPU choice
//  result       out  2        00 none, 01 player win, 10 CPU win, 11 tie
//  result_valid out  1        high in REVEAL and OVER
//  player_score out  SCORE_W  player wins this match
//  cpu_score    out  SCORE_W  CPU wins this match
//  round_cnt    out  ROUND_W  judged rounds this match
//  match_over   out  1        high in OVER
//  lfsr         out  LFSR_W   current LFSR state
// BEHAVIOUR
//  Reset (Clear=0): state WAIT_REL; lfsr=SEED (or 1); all other outputs 0; sync flops 000.
//  punch passes 2-flop sync -> p_s; p_prev = p_s delayed 1 cycle. LFSR steps every cycle, never stalls.
//  Accept = state IDLE && p_prev==000 && p_s is one-hot. Multi-hot/000 never accepted.
//  FSM:
//   WAIT_REL: -> IDLE when p_s==000.
//   IDLE: on accept latch player_choice, -> DRAW.
//   DRAW: sample c = force_en ? force_choice : lfsr[1:0]; c==11 -> stay (retry next cycle, unbiased);
//         else latch cpu_choice, -> JUDGE. Latency accept->JUDGE >= 1 cycle, unbounded only on retry.
//   JUDGE (1 cycle): d=(player-cpu) mod 3: 0 tie, 1 player win, 2 CPU win; set result;
//         increment winner score; round_cnt+1 (wraps). -> REVEAL, load reveal counter.
//   REVEAL: hold REVEAL_CYCLES cycles; then any score==WIN_SCORE -> OVER, else -> WAIT_REL.
//   OVER: match_over=1, outputs frozen, punches ignored.
//  Scores cannot exceed WIN_SCORE (match ends there); no wrap possible.
//  new_match (any state, priority over punch/accept): next cycle scores, round_cnt, result,
//   player/cpu_choice, match_over = 0; state -> WAIT_REL. lfsr unaffected.
//  result/choices hold their last values in WAIT_REL/IDLE until next JUDGE; result_valid low there.
//  Reset mid-round: immediate return to reset values, no partial score update.
// TESTING
//  Reset SEED=1, LFSR_W=16: lfsr sequence 1,2,4,8,... matches software model for 1000 cycles; all outputs 0.
//  force_en=1 choice 00, punch 010 held 3 cycles -> one round, result=01, player_score=1, round_cnt=1.
//  force 10, punch 010 -> result=10; force 01, punch 010 -> result=11; scores unchanged by tie.
//  Punch held through REVEAL, then 011 pressed -> no new round until 000 seen then valid one-hot.
//  WIN_SCORE=3: three player wins -> match_over=1 after REVEAL; further punches ignored; new_match -> scores 0.
//  force_choice=11 for 5 cycles then 00 -> stays DRAW 5 cycles, then judges with cpu_choice=00.

Source files
------------

// File: rtl/rps_match_engine.sv
// Rock-paper-scissors match controller: synchronises punch buttons, draws an unbiased
// CPU choice from a free-running LFSR, judges rounds, keeps scores and ends the match at WIN_SCORE.
module rps_match_engine #(
  parameter int                LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] TAPS          = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED          = 16'h0001,
  parameter int                REVEAL_CYCLES = 8,
  parameter int                WIN_SCORE     = 3,
  parameter int                SCORE_W       = 4,
  parameter int                ROUND_W       = 6
) (
  input  logic               CLK,
  input  logic               Clear,
  input  logic [2:0]         punch,
  input  logic               new_match,
  input  logic               force_en,
  input  logic [1:0]         force_choice,
  output logic [1:0]         player_choice,
  output logic [1:0]         cpu_choice,
  output logic [1:0]         result,
  output logic               result_valid,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] cpu_score,
  output logic [ROUND_W-1:0] round_cnt,
  output logic               match_over,
  output logic [LFSR_W-1:0]  lfsr
);

  localparam logic [2:0] S_WAIT_REL = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_DRAW     = 3'd2;
  localparam logic [2:0] S_JUDGE    = 3'd3;
  localparam logic [2:0] S_REVEAL   = 3'd4;
  localparam logic [2:0] S_OVER     = 3'd5;

  localparam int RC_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  // An all-zero seed would lock the LFSR up forever.
  localparam logic [LFSR_W-1:0] SEED_EFF =
    (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  logic [2:0]         r_state;
  logic [LFSR_W-1:0]  r_lfsr;
  logic [2:0]         r_p_s1;
  logic [2:0]         r_p_s;
  logic [2:0]         r_p_prev;
  logic [1:0]         r_player_choice;
  logic [1:0]         r_cpu_choice;
  logic [1:0]         r_result;
  logic [SCORE_W-1:0] r_player_score;
  logic [SCORE_W-1:0] r_cpu_score;
  logic [ROUND_W-1:0] r_round_cnt;
  logic [RC_W-1:0]    r_reveal_cnt;

  logic               w_p_onehot;
  logic               w_accept;
  logic [1:0]         w_punch_code;
  logic [1:0]         w_cpu_draw;
  logic [2:0]         w_diff;
  logic [1:0]         w_outcome;
  logic               w_win_reached;

  assign w_p_onehot = (r_p_s == 3'b001) || (r_p_s == 3'b010) || (r_p_s == 3'b100);
  // Requiring a released button the cycle before stops a held press from re-triggering.
  assign w_accept   = (r_state == S_IDLE) && (r_p_prev == 3'b000) && w_p_onehot;
  assign w_cpu_draw = force_en ? force_choice : r_lfsr[1:0];

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    w_punch_code = 2'b00;
    case (r_p_s)
      3'b010:  w_punch_code = 2'b01;
      3'b100:  w_punch_code = 2'b10;
      default: w_punch_code = 2'b00;
    endcase
  end

  // (player - cpu) mod 3; the +3 form stays non-negative for both inputs in 0..2.
  assign w_diff = (r_player_choice >= r_cpu_choice)
                ? {1'b0, r_player_choice} - {1'b0, r_cpu_choice}
                : {1'b0, r_player_choice} + 3'd3 - {1'b0, r_cpu_choice};

  always_comb begin
    w_outcome = 2'b11;
    case (w_diff)
      3'd1:    w_outcome = 2'b01;
      3'd2:    w_outcome = 2'b10;
      default: w_outcome = 2'b11;
    endcase
  end

  assign w_win_reached = (r_player_score == SCORE_W'(WIN_SCORE)) ||
                         (r_cpu_score    == SCORE_W'(WIN_SCORE));

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      r_lfsr   <= SEED_EFF;
      r_p_s1   <= 3'b000;
      r_p_s    <= 3'b000;
      r_p_prev <= 3'b000;
    end else begin
      r_lfsr   <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
      r_p_s1   <= punch;
      r_p_s    <= r_p_s1;
      r_p_prev <= r_p_s;
    end
  end

  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      r_state         <= S_WAIT_REL;
      r_player_choice <= 2'b00;
      r_cpu_choice    <= 2'b00;
      r_result        <= 2'b00;
      r_player_score  <= '0;
      r_cpu_score     <= '0;
      r_round_cnt     <= '0;
      r_reveal_cnt    <= '0;
    end else if (new_match) begin
      r_state         <= S_WAIT_REL;
      r_player_choice <= 2'b00;
      r_cpu_choice    <= 2'b00;
      r_result        <= 2'b00;
      r_player_score  <= '0;
      r_cpu_score     <= '0;
      r_round_cnt     <= '0;
      r_reveal_cnt    <= '0;
    end else begin
      case (r_state)
        S_WAIT_REL: begin
          if (r_p_s == 3'b000) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_accept) begin
            r_player_choice <= w_punch_code;
            r_state         <= S_DRAW;
          end
        end
        S_DRAW: begin
          // Code 11 is rejected and redrawn so the three choices stay equally likely.
          if (w_cpu_draw != 2'b11) begin
            r_cpu_choice <= w_cpu_draw;
            r_state      <= S_JUDGE;
          end
        end
        S_JUDGE: begin
          r_result <= w_outcome;
          if (w_outcome == 2'b01) r_player_score <= r_player_score + SCORE_W'(1);
          if (w_outcome == 2'b10) r_cpu_score    <= r_cpu_score + SCORE_W'(1);
          r_round_cnt  <= r_round_cnt + ROUND_W'(1);
          r_reveal_cnt <= RC_W'(REVEAL_CYCLES - 1);
          r_state      <= S_REVEAL;
        end
        S_REVEAL: begin
          if (r_reveal_cnt == '0) r_state <= w_win_reached ? S_OVER : S_WAIT_REL;
          else                    r_reveal_cnt <= r_reveal_cnt - RC_W'(1);
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: r_state <= S_WAIT_REL;
      endcase
    end
  end

  assign player_choice = r_player_choice;
  assign cpu_choice    = r_cpu_choice;
  assign result        = r_result;
  assign result_valid  = (r_state == S_REVEAL) || (r_state == S_OVER);
  assign player_score  = r_player_score;
  assign cpu_score     = r_cpu_score;
  assign round_cnt     = r_round_cnt;
  assign match_over    = (r_state == S_OVER);
  assign lfsr          = r_lfsr;

endmodule
